// File: rtl/regfile_exec_stage.sv
// Execute/write-back stage behind the 8-entry register file: single-cycle ALU ops,
// an iterative shift-add multiplier that stalls issue, and a pending-destination hazard output.
module regfile_exec_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [2:0]       rd,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             wb_we,
  output logic [2:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic             pend_valid,
  output logic [2:0]       pend_reg,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic             accept;
  logic             wb_we_reg;
  logic [2:0]       wb_reg_reg;
  logic [WIDTH-1:0] wb_data_reg;
  logic             flag_zero_reg;
  logic             flag_carry_reg;

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [2:0]       mul_rd_reg;
  logic [WIDTH-1:0] acc_step;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] alu_result;
  logic [SHW:0][WIDTH-1:0] shift_stage;

  assign accept = in_valid & in_ready;

  // SUB reuses the adder as rs1 + ~rs2 + 1, so carry out means "no borrow".
  assign add_cin = (op == OP_SUB);
  assign add_b   = add_cin ? ~rs2_data : rs2_data;
  assign add_ext = {1'b0, rs1_data} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // Logarithmic left shifter: stage gi shifts by 2**gi when amount bit gi is set.
  assign shift_stage[0] = rs1_data;
  for (genvar gi = 0; gi < SHW; gi++) begin : g_sll
    localparam int STEP = 1 << gi;
    assign shift_stage[gi+1] = rs2_data[gi] ? (shift_stage[gi] << STEP) : shift_stage[gi];
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD, OP_SUB: alu_result = add_ext[WIDTH-1:0];
      OP_AND:         alu_result = rs1_data & rs2_data;
      OP_OR:          alu_result = rs1_data | rs2_data;
      OP_XOR:         alu_result = rs1_data ^ rs2_data;
      OP_SLL:         alu_result = shift_stage[SHW];
      OP_PASS:        alu_result = rs2_data;
      default:        alu_result = '0;
    endcase
  end

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == S_IDLE);
    case (state_reg)
      S_IDLE: if (accept && (op == OP_MUL)) state_next = S_MUL;
      S_MUL:  if (cnt_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_reg      <= 1'b0;
      wb_reg_reg     <= '0;
      wb_data_reg    <= '0;
      flag_zero_reg  <= 1'b0;
      flag_carry_reg <= 1'b0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      mul_rd_reg     <= '0;
    end else begin
      wb_we_reg <= 1'b0;
      if (accept && (op != OP_MUL)) begin
        wb_we_reg     <= (rd != 3'd0);
        wb_reg_reg    <= rd;
        wb_data_reg   <= alu_result;
        flag_zero_reg <= (alu_result == '0);
        if ((op == OP_ADD) || (op == OP_SUB)) flag_carry_reg <= add_ext[WIDTH];
      end else if (accept) begin
        mcand_reg  <= rs1_data;
        mplier_reg <= rs2_data;
        acc_reg    <= '0;
        cnt_reg    <= CNT_LAST;
        mul_rd_reg <= rd;
      end
      if (state_reg == S_MUL) begin
        acc_reg    <= acc_step;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        if (cnt_reg == '0) begin
          // Final step: the last partial product is folded in on the way to write-back.
          wb_we_reg     <= (mul_rd_reg != 3'd0);
          wb_reg_reg    <= mul_rd_reg;
          wb_data_reg   <= acc_step;
          flag_zero_reg <= (acc_step == '0);
        end else begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
      end
    end
  end

  // A MUL destination is outstanding from the first iteration until its write-back cycle.
  assign pend_valid = ((state_reg == S_MUL) && (mul_rd_reg != 3'd0)) || wb_we_reg;
  assign pend_reg   = (state_reg == S_MUL) ? mul_rd_reg : wb_reg_reg;

  assign wb_we      = wb_we_reg;
  assign wb_reg     = wb_reg_reg;
  assign wb_data    = wb_data_reg;
  assign flag_zero  = flag_zero_reg;
  assign flag_carry = flag_carry_reg;

endmodule

// File: doc/regfile_exec_stage.md
Name: regfile_exec_stage

Overview:
Execute/write-back stage directly downstream of the 8-entry register file. It takes both read-port values plus an opcode and destination, computes the result, and drives the register file's write port (write enable, write address, write data). Single-cycle ALU ops complete in one cycle. MUL is an iterative shift-add that runs WIDTH cycles and back-pressures upstream. It also exports a pending-destination hazard signal for the issuing logic.

Parameters:
WIDTH, 4, data width; matches the register file's data width (must be >= 2, power of 2).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation presented this cycle
in_ready  output  1  stage can accept; accept = in_valid & in_ready
op  input  3  opcode (see Behaviour)
rd  input  3  destination register address
rs1_data  input  WIDTH  register file read_data1
rs2_data  input  WIDTH  register file read_data2
wb_we  output  1  write enable to register file (one-cycle pulse)
wb_reg  output  3  write address to register file
wb_data  output  WIDTH  write data to register file
pend_valid  output  1  a destination write is outstanding
pend_reg  output  3  outstanding destination address
flag_zero  output  1  last completed result == 0
flag_carry  output  1  carry of last ADD/SUB

Behaviour:
- Opcodes: 000 ADD, 001 SUB (rs1 - rs2 = rs1 + ~rs2 + 1), 010 AND, 011 OR, 100 XOR.
- Opcodes continued: 101 SLL (rs1 << rs2[log2(WIDTH)-1:0]), 110 PASS (rs2), 111 MUL (low WIDTH bits of rs1*rs2).
- All results are truncated to WIDTH bits. Carry is bit WIDTH of the (WIDTH+1)-bit sum. For SUB, carry = 1 means no borrow.
- FSM states: IDLE, MUL. in_ready = (state == IDLE). Inputs are ignored when not accepted.
- Single-cycle op accepted at cycle T:
  - At T+1: wb_we = (rd != 0); wb_reg = rd; wb_data = result.
  - At T+1: flag_zero is updated; flag_carry is updated only for ADD/SUB.
- MUL accepted at T:
  - Load mcand = rs1, mplier = rs2, acc = 0, cnt = WIDTH-1; go to MUL.
  - Each MUL cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1.
  - When cnt == 0, register the final acc to wb and return to IDLE; otherwise cnt--.
  - in_ready is low for T+1..T+WIDTH. wb_we pulses at T+WIDTH+1, when in_ready is high again. flag_zero is updated then; flag_carry is unchanged.
- wb_we is high for exactly one cycle per completed op with rd != 0. wb_reg and wb_data hold their last values otherwise.
- rd == 0: the result is computed and flag_zero is updated, but wb_we stays 0. Register 0 is never written.
- Back-to-back: a new single-cycle op may be accepted every cycle in IDLE, including the cycle its predecessor's wb_we is high.
- pend_valid = (state == MUL) | wb_we, with rd != 0 in both cases. pend_reg = destination of that op.
  - The register file's write lands at the end of the wb_we cycle, so a read of pend_reg during pend_valid returns stale data.
  - Upstream must not issue a dependent read while pend_valid & (rs == pend_reg). This stage does no forwarding.
- Reset (rst = 1 at a rising edge):
  - Outputs: state = IDLE, wb_we = 0, wb_reg = 0, wb_data = 0, flags = 0, pend_valid = 0, in_ready = 1 from the next cycle.
  - Reset mid-MUL aborts the op: no write-back ever occurs. Reset has priority over accept.
- in_valid during MUL: not accepted, no state change. The op must be held by upstream.

Test Plan:
- ADD rs1=9, rs2=8, rd=2 -> next cycle: wb_we=1, wb_reg=2, wb_data=1, flag_carry=1, flag_zero=0.
- SUB rs1=3, rs2=3, rd=5, then SUB rs1=2, rs2=3, rd=5 back-to-back:
  - first -> wb_data=0, zero=1, carry=1;
  - second -> wb_data=15, zero=0, carry=0;
  - wb_we high on two consecutive cycles.
- MUL rs1=7, rs2=6, rd=3 at T -> in_ready=0 for T+1..T+4; wb_we=1, wb_data=10 (42 mod 16) at T+5; pend_valid=1, pend_reg=3 for T+1..T+5.
- PASS rs2=12, rd=0 -> wb_we stays 0, flag_zero=0, pend_valid stays 0.
- MUL 3*5, rd=4, with in_valid held high carrying an XOR at T+2 -> XOR accepted only at T+5. MUL wb (15) at T+5, XOR wb at T+6.
- MUL 3*5 with rst=1 at T+2 -> no wb_we at any later cycle, state IDLE, in_ready=1, flags=0.
